// File: rtl/axi_clock_divider_mc_if.sv
// Bundle of per-channel run requests, packed period/high-time config and divider outputs.
// The master drives the run requests and config; the slave (the divider) drives clk_div, tick and running.
interface axi_clock_divider_mc_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CHANNELS       = 4
);
    logic [CHANNELS-1:0]                enable;
    logic                               sync_start;
    logic [CHANNELS*AXI_DATA_WIDTH-1:0] clockDiv;
    logic [CHANNELS*AXI_DATA_WIDTH-1:0] clockHigh;
    logic [CHANNELS-1:0]                clk_div;
    logic [CHANNELS-1:0]                tick;
    logic [CHANNELS-1:0]                running;

    modport master (
        output enable, sync_start, clockDiv, clockHigh,
        input  clk_div, tick, running
    );

    modport slave (
        input  enable, sync_start, clockDiv, clockHigh,
        output clk_div, tick, running
    );
endinterface

// File: rtl/axi_clock_divider_mc.sv
// Multi-channel programmable-duty divider; clk_div/tick registered, change on the edge that samples enable/sync.
// No backpressure: config is shadowed and applied only at start, wrap or sync.
module axi_clock_divider_mc #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CHANNELS       = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    axi_clock_divider_mc_if.slave  bus
);
    localparam int W = AXI_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    logic [CHANNELS-1:0] clk_div_w;
    logic [CHANNELS-1:0] tick_w;
    logic [CHANNELS-1:0] running_w;

    generate
        for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
            state_t         state_q;
            logic [W-1:0]   count_q;
            logic [W-1:0]   p_q, h_q;
            logic [W-1:0]   p_d, h_d;
            logic [W-1:0]   div_w, high_w, count_inc;
            logic           clk_div_q, tick_q;
            logic           en_w, wrap_w;

            assign div_w     = bus.clockDiv[n*W +: W];
            assign high_w    = bus.clockHigh[n*W +: W];
            assign en_w      = bus.enable[n];
            assign wrap_w    = (count_q == (p_q - W'(1)));
            assign count_inc = count_q + W'(1);

            // Clamp so the output always toggles: P >= 2, 1 <= H <= P-1.
            always_comb begin
                p_d = (div_w < W'(2)) ? W'(2) : div_w;
                if (high_w == '0)
                    h_d = W'(1);
                else if (high_w >= p_d)
                    h_d = p_d - W'(1);
                else
                    h_d = high_w;
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    state_q   <= IDLE;
                    count_q   <= '0;
                    p_q       <= W'(2);
                    h_q       <= W'(1);
                    clk_div_q <= 1'b0;
                    tick_q    <= 1'b0;
                end else begin
                    tick_q <= 1'b0;
                    case (state_q)
                        IDLE: begin
                            count_q   <= '0;
                            clk_div_q <= 1'b0;
                            if (en_w) begin
                                state_q   <= RUN;
                                p_q       <= p_d;
                                h_q       <= h_d;
                                clk_div_q <= 1'b1;
                                tick_q    <= 1'b1;
                            end
                        end
                        RUN, STOP: begin
                            if (state_q == RUN && bus.sync_start) begin
                                state_q   <= en_w ? RUN : STOP;
                                count_q   <= '0;
                                p_q       <= p_d;
                                h_q       <= h_d;
                                clk_div_q <= 1'b1;
                                tick_q    <= 1'b1;
                            end else if (wrap_w) begin
                                // Without a run request at the period end the channel parks; no new period starts.
                                count_q <= '0;
                                if (en_w) begin
                                    state_q   <= RUN;
                                    p_q       <= p_d;
                                    h_q       <= h_d;
                                    clk_div_q <= 1'b1;
                                    tick_q    <= 1'b1;
                                end else begin
                                    state_q   <= IDLE;
                                    clk_div_q <= 1'b0;
                                end
                            end else begin
                                state_q   <= en_w ? RUN : STOP;
                                count_q   <= count_inc;
                                clk_div_q <= (count_inc < h_q);
                            end
                        end
                        default: begin
                            state_q   <= IDLE;
                            count_q   <= '0;
                            clk_div_q <= 1'b0;
                        end
                    endcase
                end
            end

            assign clk_div_w[n] = clk_div_q;
            assign tick_w[n]    = tick_q;
            assign running_w[n] = (state_q != IDLE);
        end
    endgenerate

    assign bus.clk_div = clk_div_w;
    assign bus.tick    = tick_w;
    assign bus.running = running_w;
endmodule

// File: tb/tb_axi_clock_divider_mc.sv
// Directed bench for axi_clock_divider_mc: hand-computed waveforms for division, clamping,
// boundary reload, stop/resume, sync alignment and asynchronous reset.
module tb_axi_clock_divider_mc;
    localparam int W  = 32;
    localparam int CH = 4;

    logic clk;
    logic rstn;
    int   tests_run;
    int   tests_failed;

    axi_clock_divider_mc_if #(.AXI_DATA_WIDTH(W), .CHANNELS(CH)) ifc ();

    axi_clock_divider_mc #(.AXI_DATA_WIDTH(W), .CHANNELS(CH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input logic [31:0] d, input logic [31:0] h);
        ifc.clockDiv[ch*W +: W]  = d;
        ifc.clockHigh[ch*W +: W] = h;
    endtask

    // Patterns are MSB-first: bit [len-1] is the first observed cycle.
    task automatic run_pat(input string tag, input int ch, input int len,
                           input logic [31:0] dp, input logic [31:0] tp, input logic [31:0] rp);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk($sformatf("%s_div[%0d]", tag, i), 32'(ifc.clk_div[ch]), 32'(dp[len-1-i]));
            chk($sformatf("%s_tick[%0d]", tag, i), 32'(ifc.tick[ch]), 32'(tp[len-1-i]));
            chk($sformatf("%s_run[%0d]", tag, i), 32'(ifc.running[ch]), 32'(rp[len-1-i]));
        end
    endtask

    task automatic vec(input string tag, input logic [3:0] d, input logic [3:0] t);
        @(negedge clk);
        chk({tag, "_div"}, 32'(ifc.clk_div), 32'(d));
        chk({tag, "_tick"}, 32'(ifc.tick), 32'(t));
    endtask

    task automatic stop_and_idle(input string tag, input int ch);
        ifc.enable[ch] = 1'b0;
        repeat (10) @(negedge clk);
        chk({tag, "_idle_run"}, 32'(ifc.running[ch]), 32'd0);
        chk({tag, "_idle_div"}, 32'(ifc.clk_div[ch]), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn           = 1'b0;
        ifc.enable     = '0;
        ifc.sync_start = 1'b0;
        ifc.clockDiv   = '0;
        ifc.clockHigh  = '0;

        repeat (2) @(negedge clk);
        chk("rst_div", 32'(ifc.clk_div), 32'd0);
        chk("rst_tick", 32'(ifc.tick), 32'd0);
        chk("rst_run", 32'(ifc.running), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_run", 32'(ifc.running), 32'd0);

        // Basic P=4 H=2
        cfg(0, 4, 2);
        ifc.enable[0] = 1'b1;
        run_pat("basic", 0, 8, 32'b11001100, 32'b10001000, 32'b11111111);
        // Dropping enable at count P-1 parks on that same edge
        ifc.enable[0] = 1'b0;
        run_pat("stop_at_wrap", 0, 2, 32'b00, 32'b00, 32'b00);

        // Clamp: P=0 -> 2, H=7 -> 1
        cfg(0, 0, 7);
        ifc.enable[0] = 1'b1;
        run_pat("clampP", 0, 8, 32'b10101010, 32'b10101010, 32'hFF);
        stop_and_idle("clampP", 0);

        // Clamp: H=0 -> 1
        cfg(0, 5, 0);
        ifc.enable[0] = 1'b1;
        run_pat("clampH0", 0, 10, 32'b1000010000, 32'b1000010000, 32'h3FF);
        stop_and_idle("clampH0", 0);

        // Clamp: H=9 -> P-1
        cfg(0, 5, 9);
        ifc.enable[0] = 1'b1;
        run_pat("clampHhi", 0, 10, 32'b1111011110, 32'b1000010000, 32'h3FF);
        stop_and_idle("clampHhi", 0);

        // Boundary reload: new config at count 2 affects only the next period
        cfg(0, 8, 4);
        ifc.enable[0] = 1'b1;
        run_pat("reload_a", 0, 3, 32'b111, 32'b100, 32'b111);
        cfg(0, 3, 1);
        run_pat("reload_b", 0, 11, 32'b10000100100, 32'b00000100100, 32'h7FF);
        stop_and_idle("reload", 0);

        // Clean stop: P=6 H=3, enable dropped at count 1
        cfg(0, 6, 3);
        ifc.enable[0] = 1'b1;
        run_pat("stop_a", 0, 2, 32'b11, 32'b10, 32'b11);
        ifc.enable[0] = 1'b0;
        run_pat("stop_b", 0, 6, 32'b100000, 32'b000000, 32'b111100);

        // Resume during STOP: no gap
        ifc.enable[0] = 1'b1;
        run_pat("resume_a", 0, 2, 32'b11, 32'b10, 32'b11);
        ifc.enable[0] = 1'b0;
        run_pat("resume_b", 0, 1, 32'b1, 32'b0, 32'b1);
        ifc.enable[0] = 1'b1;
        run_pat("resume_c", 0, 9, 32'b000111000, 32'b000100000, 32'h1FF);
        stop_and_idle("resume", 0);

        // Sync alignment: ch0 P=4 H=2, ch1 P=6 H=3 started one cycle apart
        cfg(0, 4, 2);
        cfg(1, 6, 3);
        ifc.enable[0] = 1'b1;
        vec("sync_A", 4'b0001, 4'b0001);
        ifc.enable[1] = 1'b1;
        vec("sync_B", 4'b0011, 4'b0010);
        vec("sync_C", 4'b0010, 4'b0000);
        ifc.sync_start = 1'b1;
        vec("sync_D", 4'b0011, 4'b0011);
        ifc.sync_start = 1'b0;
        vec("sync_E", 4'b0011, 4'b0000);
        vec("sync_F", 4'b0010, 4'b0000);
        vec("sync_G", 4'b0000, 4'b0000);
        vec("sync_H", 4'b0001, 4'b0001);
        vec("sync_I", 4'b0001, 4'b0000);
        vec("sync_J", 4'b0010, 4'b0010);
        vec("sync_K", 4'b0010, 4'b0000);
        // ch0 is at count P-1: sync coincides with its wrap
        ifc.sync_start = 1'b1;
        vec("sync_L", 4'b0011, 4'b0011);
        ifc.sync_start = 1'b0;
        vec("sync_M", 4'b0011, 4'b0000);
        chk("sync_M_run", 32'(ifc.running), 32'h3);

        // Asynchronous reset mid-period
        #2 rstn = 1'b0;
        #1;
        chk("arst_div", 32'(ifc.clk_div), 32'd0);
        chk("arst_tick", 32'(ifc.tick), 32'd0);
        chk("arst_run", 32'(ifc.running), 32'd0);
        @(negedge clk);
        cfg(0, 3, 1);
        rstn = 1'b1;
        vec("rel_1", 4'b0011, 4'b0011);
        chk("rel_1_run", 32'(ifc.running), 32'h3);
        vec("rel_2", 4'b0010, 4'b0000);
        vec("rel_3", 4'b0010, 4'b0000);
        vec("rel_4", 4'b0001, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
